// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus bundle seen by the memory-mapped UART transmitter.
// The CPU drives the master side; the UART responds on the slave side.
interface mmio_uart_tx_if;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_we;
   logic [2:0]  dmem_funct3;
   logic [31:0] dmem_rdata;
   logic        sel;

   modport master (
      output dmem_addr, dmem_wdata, dmem_we, dmem_funct3,
      input  dmem_rdata, sel
   );

   modport slave (
      input  dmem_addr, dmem_wdata, dmem_we, dmem_funct3,
      output dmem_rdata, sel
   );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: 16-byte register window, TX FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frames, STATUS bit 8 set).
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic             clk,
   input  logic             rst,
   mmio_uart_tx_if.slave    bus,
   output logic             uart_tx,
   output logic             tx_busy
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd4;
   localparam logic       PAR_EN = 1'b1;
`else
   localparam logic       PAR_EN = 1'b0;
`endif

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count, count_n;
   logic             ovf;
   logic [15:0]      div, bit_len, timer, timer_n;
   logic [2:0]       state, state_n, bit_idx, bit_idx_n;
   logic [7:0]       tx_byte;
   logic             tx_n;

   logic [1:0]  ofs;
   logic        wr_en, push_req, push, pop, full, empty, ovf_set;
   logic [3:0]  cnt4;
   logic [31:0] status;
   logic        unused_bits;

   // A divisor of zero would stall the bit timer, so it behaves as one clock per bit.
   function automatic logic [15:0] clamp_div(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

`ifdef UART_TX_PARITY_EN
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction
`endif

   assign bus.sel     = (bus.dmem_addr[31:4] == BASE_ADDR[31:4]);
   assign ofs         = bus.dmem_addr[3:2];
   assign wr_en       = bus.dmem_we & bus.sel;
   assign unused_bits = ^{bus.dmem_wdata[31:16], bus.dmem_addr[1:0]};

   assign full     = (count == CNT_FULL);
   assign empty    = (count == '0);
   assign pop      = (state == IDLE) & ~empty;
   assign push_req = wr_en & (ofs == 2'd0);
   // A pop in the same cycle frees a slot, so a store into a full FIFO still lands.
   assign push     = push_req & (~full | pop);
   assign ovf_set  = push_req & full & ~pop;

   always_comb begin
      count_n = count;
      if (push && !pop)
         count_n = count + CNT_ONE;
      else if (!push && pop)
         count_n = count - CNT_ONE;
   end

   assign cnt4   = 4'(count);
   assign status = {23'b0, PAR_EN, cnt4, ovf, tx_busy, empty, full};

   always_comb begin
      bus.dmem_rdata = 32'd0;
      if (bus.sel) begin
         case (ofs)
            2'd1:    bus.dmem_rdata = status;
            2'd2:    bus.dmem_rdata = {16'b0, div};
            default: bus.dmem_rdata = 32'd0;
         endcase
      end
   end

   always_comb begin
      state_n   = state;
      bit_idx_n = bit_idx;
      tx_n      = uart_tx;
      timer_n   = (state != IDLE && timer != 16'd0) ? timer - 16'd1 : timer;
      case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (!empty) begin
               state_n = START;
               timer_n = clamp_div(div) - 16'd1;
               tx_n    = 1'b0;
            end
         end
         START: if (timer == 16'd0) begin
            state_n   = DATA;
            bit_idx_n = 3'd0;
            timer_n   = bit_len - 16'd1;
            tx_n      = tx_byte[0];
         end
         DATA: if (timer == 16'd0) begin
            timer_n = bit_len - 16'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_n = PARITY;
               tx_n    = even_parity(tx_byte);
`else
               state_n = STOP;
               tx_n    = 1'b1;
`endif
            end else begin
               bit_idx_n = bit_idx + 3'd1;
               tx_n      = tx_byte[bit_idx + 3'd1];
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (timer == 16'd0) begin
            state_n = STOP;
            timer_n = bit_len - 16'd1;
            tx_n    = 1'b1;
         end
`endif
         STOP: if (timer == 16'd0) begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.dmem_wdata[7:0];
      if (pop)
         tx_byte <= mem[rd_ptr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         timer   <= 16'd0;
         bit_idx <= 3'd0;
         bit_len <= 16'd1;
         uart_tx <= 1'b1;
         tx_busy <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ovf     <= 1'b0;
         div     <= DEFAULT_DIV;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         bit_idx <= bit_idx_n;
         uart_tx <= tx_n;
         tx_busy <= (state_n != IDLE) | (count_n != '0);
         count   <= count_n;
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            rd_ptr  <= rd_ptr + PTR_ONE;
            bit_len <= clamp_div(div);
         end
         if (wr_en && ofs == 2'd1)
            ovf <= 1'b0;
         else if (ovf_set)
            ovf <= 1'b1;
         if (wr_en && ofs == 2'd2 && bus.dmem_funct3 == 3'b010)
            div <= bus.dmem_wdata[15:0];
      end
   end
endmodule
